// File: rtl/key_extract_pkg.sv
// Shared defaults and the offset range predicate for the key extraction pipeline.
package key_extract_pkg;

    localparam int HDR_W_DEF      = 2048;
    localparam int OFF_W_DEF      = 12;
    localparam int FIELD_W_DEF    = 144;
    localparam int NUM_FIELDS_DEF = 4;

    // True when a field starting at bit offset 'off' would run past the header end.
    function automatic logic off_out_of_range(input int unsigned off,
                                              input int unsigned hdr_w,
                                              input int unsigned field_w);
        return (off > (hdr_w - field_w));
    endfunction

endpackage

// File: rtl/key_field_sel.sv
// Combinational selection of one field from the header at a bit offset counted
// from the header MSB. Out-of-range offsets never address header bits.
module key_field_sel
    import key_extract_pkg::*;
#(
    parameter int HDR_W   = HDR_W_DEF,
    parameter int OFF_W   = OFF_W_DEF,
    parameter int FIELD_W = FIELD_W_DEF
) (
    input  logic [HDR_W-1:0]   hdr_i,
    input  logic [OFF_W-1:0]   off_i,
    input  logic               en_i,
    output logic [FIELD_W-1:0] field_o,
    output logic               err_o
);

    localparam int unsigned MAX_OFF = HDR_W - FIELD_W;

    logic        oor_s;
    int unsigned shamt_s;

    // Right-shift the header so the selected field lands in the low FIELD_W bits;
    // an out-of-range offset uses a harmless shift and the result is forced to zero.
    always_comb begin
        oor_s   = off_out_of_range(32'(off_i), 32'(HDR_W), 32'(FIELD_W));
        shamt_s = 32'd0;
        if (oor_s) begin
            shamt_s = 32'd0;
        end else begin
            shamt_s = MAX_OFF - 32'(off_i);
        end
        if (en_i && !oor_s) begin
            field_o = FIELD_W'(hdr_i >> shamt_s);
            err_o   = 1'b0;
        end else begin
            field_o = {FIELD_W{1'b0}};
            err_o   = en_i && oor_s;
        end
    end

endmodule

// File: rtl/key_extract_pipe.sv
// Two-stage key extraction pipeline: S1 captures header/offsets/enables, S2 holds
// the extracted key and per-field error flags behind a valid/ready handshake.
module key_extract_pipe
    import key_extract_pkg::*;
#(
    parameter int HDR_W      = HDR_W_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int NUM_FIELDS = NUM_FIELDS_DEF,
    parameter int KEY_W      = NUM_FIELDS * FIELD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [HDR_W-1:0]            in_hdr,
    input  logic [NUM_FIELDS*OFF_W-1:0] in_off,
    input  logic [NUM_FIELDS-1:0]       in_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [KEY_W-1:0]            out_key,
    output logic [NUM_FIELDS-1:0]       out_err,
    output logic [31:0]                 key_cnt,
    output logic [15:0]                 err_cnt
);

    if (KEY_W != NUM_FIELDS * FIELD_W) begin : g_bad_key_w
        $error("key_extract_pipe: KEY_W must equal NUM_FIELDS*FIELD_W");
    end

    // Stage S1 (datapath unreset, valid reset)
    logic                        s1_valid_q, s1_valid_d;
    logic [HDR_W-1:0]            s1_hdr_q;
    logic [NUM_FIELDS*OFF_W-1:0] s1_off_q;
    logic [NUM_FIELDS-1:0]       s1_en_q;

    // Stage S2 and statistics
    logic                  out_valid_q, out_valid_d;
    logic [KEY_W-1:0]      out_key_q, out_key_d;
    logic [NUM_FIELDS-1:0] out_err_q, out_err_d;
    logic [31:0]           key_cnt_q, key_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic                  in_ready_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic                  s2_load_s;
    logic [KEY_W-1:0]      sel_key_s;
    logic [NUM_FIELDS-1:0] sel_err_s;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        key_field_sel #(
            .HDR_W   (HDR_W),
            .OFF_W   (OFF_W),
            .FIELD_W (FIELD_W)
        ) u_sel (
            .hdr_i   (s1_hdr_q),
            .off_i   (s1_off_q[i*OFF_W +: OFF_W]),
            .en_i    (s1_en_q[i]),
            .field_o (sel_key_s[i*FIELD_W +: FIELD_W]),
            .err_o   (sel_err_s[i])
        );
    end

    // Handshake decode; S1 frees up whenever its content moves into S2 this cycle.
    always_comb begin
        out_xfer_s = out_valid_q && out_ready;
        s2_load_s  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready_s = !rst && (!s1_valid_q || !out_valid_q || out_ready);
        in_xfer_s  = in_valid && in_ready_s;
    end

    // Next-state for stage valids, key/err capture and the two counters.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;
        out_err_d   = out_err_q;
        key_cnt_d   = key_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            out_valid_d = 1'b1;
            out_key_d   = sel_key_s;
            out_err_d   = sel_err_s;
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_xfer_s) begin
            key_cnt_d = key_cnt_q + 32'd1;
            if ((|out_err_q) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            key_cnt_d = key_cnt_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Control, output and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_key_q   <= {KEY_W{1'b0}};
            out_err_q   <= {NUM_FIELDS{1'b0}};
            key_cnt_q   <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
            out_err_q   <= out_err_d;
            key_cnt_q   <= key_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // S1 datapath capture; contents are qualified by s1_valid_q so no reset needed.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            s1_hdr_q <= in_hdr;
            s1_off_q <= in_off;
            s1_en_q  <= in_en;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_err   = out_err_q;
    assign key_cnt   = key_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_key_extract_pipe.sv
// Self-checking bench for key_extract_pipe: scoreboard of expected keys filled on
// input handshakes and consumed on output handshakes, plus per-scenario checks.
module tb_key_extract_pipe;

    localparam int HDR_W   = 2048;
    localparam int OFF_W   = 12;
    localparam int FIELD_W = 144;
    localparam int NF      = 4;
    localparam int KEY_W   = NF * FIELD_W;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [NF-1:0]    err;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [HDR_W-1:0]    in_hdr;
    logic [NF*OFF_W-1:0] in_off;
    logic [NF-1:0]       in_en;
    logic                out_valid;
    logic                out_ready;
    logic [KEY_W-1:0]    out_key;
    logic [NF-1:0]       out_err;
    logic [31:0]         key_cnt;
    logic [15:0]         err_cnt;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          out_seen = 0;
    int unsigned exp_key_cnt = 0;
    logic [15:0] exp_err_cnt = 16'd0;
    logic        saw_not_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [KEY_W-1:0] prev_key;
    logic [NF-1:0]    prev_err;

    key_extract_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hdr    (in_hdr),
        .in_off    (in_off),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_err   (out_err),
        .key_cnt   (key_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extraction: bit-by-bit walk from the header MSB.
    function automatic exp_t model(input logic [HDR_W-1:0] hdr,
                                   input logic [NF*OFF_W-1:0] off,
                                   input logic [NF-1:0] en);
        exp_t r;
        r.key = '0;
        r.err = '0;
        for (int i = 0; i < NF; i++) begin
            int o;
            o = int'(off[i*OFF_W +: OFF_W]);
            if (en[i]) begin
                if (o + FIELD_W > HDR_W) r.err[i] = 1'b1;
                else for (int j = 0; j < FIELD_W; j++)
                    r.key[i*FIELD_W + FIELD_W - 1 - j] = hdr[HDR_W - 1 - o - j];
            end
        end
        return r;
    endfunction

    // Scoreboard monitor, sampled mid-cycle after inputs settle.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            prev_stall  = 1'b0;
            exp_key_cnt = 0;
            exp_err_cnt = 16'd0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_key !== prev_key || out_err !== prev_err) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b err=%b, required valid=1 err=%b and unchanged key", out_valid, out_err, prev_err);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_key: got key=%h with empty scoreboard", out_key);
                end else begin
                    e = sb_q.pop_front();
                    if (out_key !== e.key || out_err !== e.err) begin
                        errors++;
                        $display("FAIL scoreboard: got key=%h err=%b, required key=%h err=%b", out_key, out_err, e.key, e.err);
                    end
                end
                out_seen++;
                exp_key_cnt++;
                if ((|out_err) && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_hdr, in_off, in_en));
            prev_stall = out_valid && !out_ready;
            prev_key   = out_key;
            prev_err   = out_err;
        end
    end

    task automatic rand_hdr(output logic [HDR_W-1:0] h);
        for (int i = 0; i < HDR_W / 32; i++) h[i*32 +: 32] = $urandom();
    endtask

    // Present one input and hold it until the handshake is guaranteed at the next edge.
    task automatic send(input logic [HDR_W-1:0] h, input logic [NF*OFF_W-1:0] o, input logic [NF-1:0] e);
        int b;
        b = 0;
        @(negedge clk);
        in_valid = 1'b1; in_hdr = h; in_off = o; in_en = e;
        #1;
        while (!in_ready && b < 100) begin
            saw_not_ready = 1'b1;
            @(negedge clk); #1; b++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=%b, required 1 within 100 cycles", in_ready);
        end
    endtask

    task automatic send_one(input logic [HDR_W-1:0] h, input logic [NF*OFF_W-1:0] o, input logic [NF-1:0] e);
        send(h, o, e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int b;
        b = 0;
        #2;
        while (!out_valid && b < 50) begin @(negedge clk); #2; b++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL wait_out_timeout: got out_valid=0, required 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && b < 200) begin @(negedge clk); #2; b++; end
        if (b >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending keys, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++; if (key_cnt !== 32'd0) begin errors++; $display("FAIL rst_key_cnt: got %0d, required 0", key_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt); end
        checks++; if (out_key !== {KEY_W{1'b0}} || out_err !== 4'b0000) begin errors++; $display("FAIL rst_out_key: got err=%b key=%h, required zeros", out_err, out_key); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [HDR_W-1:0] h;
        logic [143:0]     a5;
        a5 = {18{8'hA5}};
        rand_hdr(h);
        h[2047:1904] = a5;
        out_ready = 1'b1;
        send(h, {NF*OFF_W{1'b0}}, 4'b0001);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_2: got out_valid=%b two cycles after accept, required 1", out_valid); end
        checks++; if (out_key[143:0] !== a5) begin errors++; $display("FAIL basic_field0: got %h, required %h", out_key[143:0], a5); end
        checks++; if (out_key[KEY_W-1:144] !== {(KEY_W-144){1'b0}} || out_err !== 4'b0000) begin errors++; $display("FAIL basic_others: got err=%b upper=%h, required 0", out_err, out_key[KEY_W-1:144]); end
        drain();
    endtask

    task automatic test_offset_edges();
        logic [HDR_W-1:0]    h;
        logic [NF*OFF_W-1:0] o;
        rand_hdr(h);
        o = '0;
        o[11:0] = 12'd1904;
        send_one(h, o, 4'b0001);
        wait_out();
        checks++; if (out_key[143:0] !== h[143:0] || out_err !== 4'b0000) begin errors++; $display("FAIL off_1904: got err=%b field=%h, required err=0000 field=%h", out_err, out_key[143:0], h[143:0]); end
        drain();
        o[11:0] = 12'd1905;
        send_one(h, o, 4'b0001);
        wait_out();
        checks++; if (out_key !== {KEY_W{1'b0}} || out_err !== 4'b0001) begin errors++; $display("FAIL off_1905: got err=%b key=%h, required err=0001 key=0", out_err, out_key); end
        drain();
        checks++; if (err_cnt !== 16'd1 || err_cnt !== exp_err_cnt) begin errors++; $display("FAIL err_cnt_one: got %0d, required 1", err_cnt); end
    endtask

    task automatic test_disabled_field();
        logic [HDR_W-1:0]    h;
        logic [NF*OFF_W-1:0] o;
        rand_hdr(h);
        o = {12'd1904, 12'd500, 12'd4000, 12'd10};
        send_one(h, o, 4'b1101);
        wait_out();
        checks++; if (out_err !== 4'b0000) begin errors++; $display("FAIL disabled_err: got %b, required 0000", out_err); end
        checks++; if (out_key[287:144] !== 144'd0) begin errors++; $display("FAIL disabled_field1: got %h, required 0", out_key[287:144]); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [HDR_W-1:0] h;
        int               start_seen;
        test_reset();
        start_seen    = out_seen;
        saw_not_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    rand_hdr(h);
                    send(h, {12'(k*7), 12'(k*300), 12'(k*100), 12'(k*250)}, 4'(k + 1));
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 3 && c <= 6);
                end
            end
        join
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        checks++; if (saw_not_ready !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: got in_ready never low, required low during stall"); end
        checks++; if (out_seen - start_seen != 8) begin errors++; $display("FAIL b2b_count: got %0d keys, required 8", out_seen - start_seen); end
        checks++; if (key_cnt !== 32'd8 || key_cnt !== exp_key_cnt) begin errors++; $display("FAIL b2b_key_cnt: got %0d, required 8", key_cnt); end
    endtask

    task automatic test_reset_inflight();
        logic [HDR_W-1:0] h;
        logic             bad;
        out_ready = 1'b0;
        rand_hdr(h);
        send(h, '0, 4'b1111);
        rand_hdr(h);
        send(h, '0, 4'b0011);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid: got %b, required 0", out_valid); end
        checks++; if (key_cnt !== 32'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_inflight_cnt: got key_cnt=%0d err_cnt=%0d, required 0", key_cnt, err_cnt); end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        bad = 1'b0;
        repeat (5) begin @(negedge clk); #1; if (out_valid !== 1'b0) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL rst_stale_key: got out_valid=1 after reset, required 0"); end
    endtask

    task automatic test_err_saturate();
        logic [HDR_W-1:0]    h;
        logic [NF*OFF_W-1:0] o;
        logic [15:0]         want [3];
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'hFFFF;
        rand_hdr(h);
        o = '0;
        o[11:0] = 12'd2000;
        out_ready = 1'b1;
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFC;
        exp_err_cnt = 16'hFFFC;
        @(negedge clk);
        release dut.err_cnt_q;
        #1;
        checks++; if (err_cnt !== 16'hFFFC) begin errors++; $display("FAIL err_preload: got %h, required fffc", err_cnt); end
        send_one(h, o, 4'b0001);
        send_one(h, o, 4'b0001);
        drain();
        checks++; if (err_cnt !== want[0] || err_cnt !== exp_err_cnt) begin errors++; $display("FAIL err_cnt_fffe: got %h, required %h", err_cnt, want[0]); end
        for (int k = 1; k < 3; k++) begin
            send_one(h, o, 4'b0001);
            drain();
            checks++; if (err_cnt !== want[k] || err_cnt !== exp_err_cnt) begin errors++; $display("FAIL err_cnt_sat: got %h, required %h", err_cnt, want[k]); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_hdr = '0; in_off = '0; in_en = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_offset_edges();
        test_disabled_field();
        test_back_to_back();
        test_reset_inflight();
        test_err_saturate();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending keys, required 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
